// File: rtl/bsg_dual_operand_unzip_pkg.sv
// bsg_dual_operand_unzip_pkg
//   Shared definitions for the dual-operand unzip block: the FSM state
//   encoding, the default data width and a small state-decode helper.
//   Ports: none (package).
//   Optional feature macro used by the top: BSG_DUAL_OPERAND_UNZIP_NAND_EN.

package bsg_dual_operand_unzip_pkg;

    // Default width of every data word and operand.
    localparam int unsigned default_width_lp = 16;

    // Encoding chosen so bit 1 alone marks "a complete pair is held",
    // which lets v_o come straight off a state flop.
    typedef enum logic [1:0] {
        EMPTY       = 2'b00,
        HAVE_A      = 2'b01,
        PAIR        = 2'b10,
        PAIR_STAGED = 2'b11
    } unzip_state_e;

    // True when the state holds a complete A/B pair.
    function automatic logic pair_valid(input unzip_state_e state);
        return state[1];
    endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// bsg_dff_reset_en
//   Width-parameterised data register with synchronous active-high reset
//   and a load enable. Reset has priority over the enable.
//   Ports:
//     clk_i   - clock, rising edge
//     reset_i - synchronous active-high reset, clears the register to 0
//     en_i    - load data_i on the next rising edge
//     data_i  - value to load
//     data_o  - current register contents

module bsg_dff_reset_en
    import bsg_dual_operand_unzip_pkg::*;
#(
    parameter int unsigned width_p = default_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    // NOTE: data registers are cleared on reset because a discarded operand
    // must never reappear on the outputs after a reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r <= '0;
        end else if (en_i) begin
            data_r <= data_i;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_dual_operand_unzip.sv
// bsg_dual_operand_unzip
//   Splits a valid/ready word stream into operand pairs: the 1st, 3rd, 5th...
//   accepted words become A, the 2nd, 4th, 6th... become B. A one-word stage
//   register lets the next A be accepted while a finished pair waits, so the
//   block sustains one pair every two cycles without a combinational path
//   from yumi_i or v_i to ready_o.
//
//   Optional feature: define BSG_DUAL_OPERAND_UNZIP_NAND_EN to add nand_o,
//   a registered bitwise ~(A & B) of the held pair.
//
//   Ports:
//     clk_i   - clock, rising edge
//     reset_i - synchronous active-high reset; discards any held words
//     v_i     - input word valid
//     data_i  - input word (alternately A then B)
//     ready_o - block accepts data_i this cycle (transfer = v_i & ready_o)
//     v_o     - operand pair valid
//     a_o     - operand A of the current pair
//     b_o     - operand B of the current pair
//     yumi_i  - consumer takes the pair this cycle (only while v_o = 1)
//     nand_o  - ~(a_o & b_o), present only with the macro defined

module bsg_dual_operand_unzip
    import bsg_dual_operand_unzip_pkg::*;
#(
    parameter int unsigned width_p = default_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] a_o,
    output logic [width_p-1:0] b_o
`ifdef BSG_DUAL_OPERAND_UNZIP_NAND_EN
   ,output logic [width_p-1:0] nand_o
`endif
);

    unzip_state_e       state_r;
    logic               xfer;
    logic               a_en;
    logic               b_en;
    logic               stage_en;
    logic [width_p-1:0] a_d;
    logic [width_p-1:0] stage_r;

    // ready_o depends only on the state flop and reset, never on v_i/yumi_i.
    // Gating with reset_i keeps it low during the reset cycle itself, while
    // still reading 1 in the very first cycle after reset releases.
    assign ready_o = ~reset_i & (state_r != PAIR_STAGED);
    assign v_o     = pair_valid(state_r);
    assign xfer    = v_i & ready_o;

    // Register load enables and the A-register source select.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_en     = 1'b0;
        b_en     = 1'b0;
        stage_en = 1'b0;
        a_d      = data_i;
        unique case (state_r)
            EMPTY: begin
                a_en = xfer;
            end
            HAVE_A: begin
                b_en = xfer;
            end
            PAIR: begin
                // With yumi the pair leaves and the new word is the next A;
                // without yumi the new word waits in the stage register.
                a_en     = xfer & yumi_i;
                stage_en = xfer & ~yumi_i;
            end
            PAIR_STAGED: begin
                a_en = yumi_i;
                a_d  = stage_r;
            end
            default: begin
                a_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= EMPTY;
        end else begin
            unique case (state_r)
                EMPTY: begin
                    if (xfer) state_r <= HAVE_A;
                end
                HAVE_A: begin
                    if (xfer) state_r <= PAIR;
                end
                PAIR: begin
                    if (yumi_i && xfer)        state_r <= HAVE_A;
                    else if (yumi_i)           state_r <= EMPTY;
                    else if (xfer)             state_r <= PAIR_STAGED;
                end
                PAIR_STAGED: begin
                    if (yumi_i) state_r <= HAVE_A;
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    bsg_dff_reset_en #(.width_p(width_p)) a_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (a_en),
        .data_i  (a_d),
        .data_o  (a_o)
    );

    bsg_dff_reset_en #(.width_p(width_p)) b_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (b_en),
        .data_i  (data_i),
        .data_o  (b_o)
    );

    bsg_dff_reset_en #(.width_p(width_p)) stage_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (stage_en),
        .data_i  (data_i),
        .data_o  (stage_r)
    );

`ifdef BSG_DUAL_OPERAND_UNZIP_NAND_EN
    logic [width_p-1:0] a_next;
    logic [width_p-1:0] b_next;
    logic [width_p-1:0] nand_r;

    // Computed from the post-edge A/B values so nand_o tracks a_o/b_o in
    // the same cycle instead of lagging by one.
    assign a_next = a_en ? a_d : a_o;
    assign b_next = b_en ? data_i : b_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            nand_r <= '0;
        end else begin
            nand_r <= ~(a_next & b_next);
        end
    end

    assign nand_o = nand_r;
`endif

endmodule

// File: tb/tb_bsg_dual_operand_unzip.sv
// tb_bsg_dual_operand_unzip
//   Self-checking bench for bsg_dual_operand_unzip. A reference model keeps
//   the accepted words as a queue of half-built and complete pairs; the
//   number of words held decides ready/valid (ready while fewer than three
//   are held, valid while a complete pair exists).

module tb_bsg_dual_operand_unzip;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic         clk;
    logic         reset_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         v_o;
    logic         yumi_i;
    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
`ifdef BSG_DUAL_OPERAND_UNZIP_NAND_EN
    logic [W-1:0] nand_o;
`endif

    bsg_dual_operand_unzip #(.width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .yumi_i  (yumi_i),
        .a_o     (a_o),
        .b_o     (b_o)
`ifdef BSG_DUAL_OPERAND_UNZIP_NAND_EN
       ,.nand_o  (nand_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [W-1:0] pend_q[$];   // accepted words not yet forming a pair
    pair_t        exp_q[$];    // complete pairs awaiting consumption
    int           n_accepted;
    int           n_popped;
    logic         seen_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int held_words();
        return pend_q.size() + 2 * exp_q.size();
    endfunction

    // One clock cycle: check outputs against the model at the negedge,
    // drive the requested inputs, then advance the model at the posedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic y);
        logic  exp_v;
        logic  exp_ready;
        pair_t p;
        @(negedge clk);
        exp_v     = (exp_q.size() != 0);
        exp_ready = (held_words() < 3);
        seen_ready = ready_o;
        check("v_o", v_o, exp_v);
        check("ready_o", ready_o, exp_ready);
        if (exp_v) begin
            check("a_o", a_o, exp_q[0].a);
            check("b_o", b_o, exp_q[0].b);
`ifdef BSG_DUAL_OPERAND_UNZIP_NAND_EN
            check("nand_o", nand_o, ~(exp_q[0].a & exp_q[0].b));
`endif
        end
        v_i    = v;
        data_i = d;
        yumi_i = y & exp_v;
        @(posedge clk);
        if (yumi_i) begin
            void'(exp_q.pop_front());
            n_popped++;
        end
        if (v_i && exp_ready) begin
            pend_q.push_back(d);
            n_accepted++;
            if (pend_q.size() == 2) begin
                p.a = pend_q.pop_front();
                p.b = pend_q.pop_front();
                exp_q.push_back(p);
            end
        end
        #1;
        v_i    = 1'b0;
        yumi_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        v_i     = 1'b1;
        data_i  = W'($urandom);
        yumi_i  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o, 1'b0);
        check("rst_v", v_o, 1'b0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i     = 1'b0;
        pend_q.delete();
        exp_q.delete();
        n_popped   = 0;
        n_accepted = 0;
        @(negedge clk);
        check("post_rst_ready", ready_o, 1'b1);
        check("post_rst_a", a_o, '0);
        check("post_rst_b", b_o, '0);
    endtask

    initial begin
        int budget;
        int drops;
        reset_i    = 1'b1;
        v_i        = 1'b0;
        yumi_i     = 1'b0;
        data_i     = '0;
        n_accepted = 0;
        n_popped   = 0;
        seen_ready = 1'b0;

        // Basic pair, latency 1
        do_reset();
        step(1'b1, 16'h00FF, 1'b0);
        step(1'b1, 16'h0F0F, 1'b0);
        @(negedge clk);
        check("basic_v", v_o, 1'b1);
        check("basic_a", a_o, 16'h00FF);
        check("basic_b", b_o, 16'h0F0F);
`ifdef BSG_DUAL_OPERAND_UNZIP_NAND_EN
        check("basic_nand", nand_o, 16'hFFF0);
`endif

        // Staging: 1,2,3 with no consumer
        do_reset();
        step(1'b1, 16'd1, 1'b0);
        step(1'b1, 16'd2, 1'b0);
        step(1'b1, 16'd3, 1'b0);
        @(negedge clk);
        check("staged_ready", ready_o, 1'b0);
        check("staged_v", v_o, 1'b1);
        check("staged_a", a_o, 16'd1);
        check("staged_b", b_o, 16'd2);
        step(1'b0, 16'd0, 1'b1);
        @(negedge clk);
        check("unstage_v", v_o, 1'b0);
        check("unstage_ready", ready_o, 1'b1);
        step(1'b1, 16'd4, 1'b0);
        @(negedge clk);
        check("next_pair_a", a_o, 16'd3);
        check("next_pair_b", b_o, 16'd4);

        // Consume and accept in the same cycle
        do_reset();
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        step(1'b1, 16'hAAAA, 1'b1);
        @(negedge clk);
        check("coincide_v", v_o, 1'b0);
        check("coincide_pops", n_popped, 1);
        step(1'b1, 16'hBBBB, 1'b0);
        @(negedge clk);
        check("coincide_a", a_o, 16'hAAAA);
        check("coincide_b", b_o, 16'hBBBB);

        // Reset mid-pair discards the held A
        do_reset();
        step(1'b1, 16'h1234, 1'b0);
        do_reset();
        step(1'b1, 16'h5555, 1'b0);
        step(1'b1, 16'h6666, 1'b0);
        @(negedge clk);
        check("rst_mid_v", v_o, 1'b1);
        check("rst_mid_a", a_o, 16'h5555);
        check("rst_mid_b", b_o, 16'h6666);

        // Sustained throughput
        do_reset();
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(16'h0100 + i), 1'b1);
            if (!seen_ready) drops++;
        end
        check("thru_pairs", n_popped, 9);
        check("thru_ready_drops", drops, 0);

        // Random streaming of 1000 words
        do_reset();
        budget = 0;
        while (n_accepted < 1000 && budget < 6000) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
            budget++;
        end
        check("rand_accepted", n_accepted, 1000);
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            step(1'b0, '0, 1'b1);
            budget++;
        end
        check("rand_drained", exp_q.size(), 0);
        check("rand_pairs", n_popped, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bsg_dual_operand_unzip.md
BSG_DUAL_OPERAND_UNZIP -- requirements
Module: bsg_dual_operand_unzip

Interface
REQ-001 Parameter width_p, default 16: width of every data word and operand.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  reset, synchronous and active-high.
REQ-004 v_i  input  1  input word valid.
REQ-005 data_i  input  width_p  input word; alternates operand A, then operand B.
REQ-006 ready_o  output  1  block can accept data_i this cycle; a transfer occurs when v_i & ready_o.
REQ-007 v_o  output  1  operand pair valid.
REQ-008 a_o  output  width_p  operand A of the current pair.
REQ-009 b_o  output  width_p  operand B of the current pair.
REQ-010 yumi_i  input  1  consumer takes the pair this cycle; legal only when v_o=1.

Function
REQ-011 The block SHALL pair stream words in arrival order: the 1st, 3rd, 5th... accepted words are A; the 2nd, 4th, 6th... are B.
REQ-012 The block SHALL hold registers a_r, b_r and stage_r, plus a 2-bit state: EMPTY, HAVE_A, PAIR, PAIR_STAGED.
REQ-013 Outputs SHALL be fully registered: v_o=1 only in PAIR or PAIR_STAGED; a_o=a_r and b_o=b_r.
REQ-014 ready_o SHALL be 1 in EMPTY, HAVE_A and PAIR, and 0 in PAIR_STAGED; ready_o SHALL NOT depend combinationally on yumi_i or v_i.
REQ-015 EMPTY with a transfer: a_r<=data_i, go to HAVE_A.
REQ-016 HAVE_A with a transfer: b_r<=data_i, go to PAIR; v_o rises the cycle after B is accepted (latency 1).
REQ-017 PAIR: yumi_i with no transfer -> EMPTY; a transfer with no yumi_i -> stage_r<=data_i, PAIR_STAGED; yumi_i and a transfer -> a_r<=data_i, HAVE_A; neither -> hold.
REQ-018 PAIR_STAGED with yumi_i: a_r<=stage_r, go to HAVE_A; without yumi_i: hold all registers.
REQ-019 a_o and b_o SHALL remain stable while v_o=1 and yumi_i=0.
REQ-020 Sustained throughput SHALL be one pair per two cycles with v_i held high and yumi_i asserted whenever v_o=1.
REQ-021 Data SHALL never be dropped or duplicated, including when yumi_i and a transfer coincide.

Reset
REQ-022 While reset_i=1, the state SHALL be EMPTY, v_o=0 and ready_o=0, and a_r, b_r and stage_r SHALL be cleared to 0.
REQ-023 Reset asserted mid-pair SHALL discard any held A, B or staged word; the first word accepted after reset is treated as A.
REQ-024 ready_o SHALL be 1 in the first cycle after reset_i deasserts.

Configuration
REQ-025 With macro BSG_DUAL_OPERAND_UNZIP_NAND_EN defined, an extra output nand_o [width_p] SHALL equal ~(a_r & b_r) bitwise, registered alongside the pair, valid when v_o=1, and 0 under reset.
REQ-026 With BSG_DUAL_OPERAND_UNZIP_NAND_EN undefined, the nand_o port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 The state encoding enum (EMPTY, HAVE_A, PAIR, PAIR_STAGED) and a default-width constant SHALL live in package bsg_dual_operand_unzip_pkg.
REQ-028 Data registers SHALL use sub-module bsg_dff_reset_en, instantiated three times (a_r, b_r, stage_r), with the FSM inline.

Verification
REQ-029 Reset, then A=16'h00FF and B=16'h0F0F on consecutive cycles -> v_o=1 the next cycle with a_o=16'h00FF and b_o=16'h0F0F; with the macro defined, nand_o=16'hFFF0.
REQ-030 Hold yumi_i=0 with words 1,2,3 sent -> state PAIR_STAGED, ready_o=0, a_o=1, b_o=2; pulse yumi_i -> state HAVE_A with a_r=3; send 4 -> next pair (3,4).
REQ-031 In PAIR, assert yumi_i and a transfer of 16'hAAAA in the same cycle -> state HAVE_A with a_r=16'hAAAA, and no pair is lost or repeated.
REQ-032 Streaming of 1000 random words with random v_i and yumi_i -> a scoreboard sees the pairs in order, with no loss or duplication.
REQ-033 Assert reset_i for one cycle after only A=16'h1234 is accepted -> the next two words form the pair, and 16'h1234 never appears on a_o.
REQ-034 v_i high continuously and yumi_i tied to v_o -> one pair every 2 cycles, and ready_o never deasserts.
